// File: rtl/mem_writer_pkg.sv
// Shared types and header-field positions for the burst-capable AXIS memory writer.
package mem_writer_pkg;

    localparam int WORD_W    = 32;
    localparam int ADDR_LSB  = 0;
    localparam int BURST_BIT = 31;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        WRITE_LAST,
        DRAIN,
        END
    } state_t;

endpackage

// File: rtl/synchronizer_n.sv
// N-flop level synchronizer for asynchronous single-bit control inputs.
module synchronizer_n #(
    parameter int STAGES = 2
)(
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rstn) sync_q <= '0;
        else       sync_q <= {sync_q[STAGES-2:0], d};
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/mem_writer_burst.sv
// AXIS packet to wide-memory writer: header selects bank/address, NREG words form one
// entry, optional burst mode auto-increments the address per entry.
module mem_writer_burst
    import mem_writer_pkg::*;
#(
    parameter int NREG = 15,
    parameter int NB   = 32,
    parameter int AW   = 16
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [WORD_W-1:0]      s_axis_tdata,
    input  logic                   s_axis_tlast,
    output logic [AW-1:0]          mem_addr,
    output logic [WORD_W*NREG-1:0] mem_din,
    output logic [NB-1:0]          mem_we,
    input  logic                   START_REG,
    output logic                   busy,
    output logic                   done,
    output logic                   err_incomplete,
    output logic                   err_bank,
    output logic [15:0]            wr_cnt
);

    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = $clog2(NREG + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NREG - 1);

    state_t                       state, state_n;
    logic                         start_s;
    logic                         acc;
    logic                         entry_full;
    logic [BW-1:0]                hdr_bank;
    logic                         bank_bad;
    logic [NREG-1:0][WORD_W-1:0]  regs;
    logic [CW-1:0]                cnt;
    logic [AW-1:0]                addr_q;
    logic [BW-1:0]                bank_q;
    logic                         burst_q;
    logic                         unused_hdr;

    synchronizer_n #(.STAGES(2)) u_start_sync (
        .clk  (clk),
        .rstn (~rst),
        .d    (START_REG),
        .q    (start_s)
    );

    assign hdr_bank   = s_axis_tdata[AW+BW-1:AW];
    assign bank_bad   = 32'(hdr_bank) >= 32'(NB);
    assign acc        = s_axis_tvalid & s_axis_tready;
    assign entry_full = (cnt == LAST_IDX);
    assign busy       = (state != IDLE);
    assign done       = (state == END);
    assign unused_hdr = ^s_axis_tdata[BURST_BIT-1:AW+BW];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n       = state;
        s_axis_tready = 1'b0;
        case (state)
            IDLE: if (start_s) state_n = HDR;
            HDR: begin
                s_axis_tready = 1'b1;
                if (acc) begin
                    if (bank_bad)          state_n = s_axis_tlast ? END : DRAIN;
                    else if (s_axis_tlast) state_n = END;
                    else                   state_n = DATA;
                end
            end
            DATA: begin
                s_axis_tready = 1'b1;
                if (acc && entry_full)        state_n = s_axis_tlast ? WRITE_LAST : WRITE;
                else if (acc && s_axis_tlast) state_n = END;
            end
            WRITE:      state_n = burst_q ? DATA : HDR;
            WRITE_LAST: state_n = END;
            DRAIN: begin
                s_axis_tready = 1'b1;
                if (acc && s_axis_tlast) state_n = END;
            end
            END:     if (!start_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs           <= '0;
            cnt            <= '0;
            addr_q         <= '0;
            bank_q         <= '0;
            burst_q        <= 1'b0;
            mem_addr       <= '0;
            mem_din        <= '0;
            mem_we         <= '0;
            err_incomplete <= 1'b0;
            err_bank       <= 1'b0;
            wr_cnt         <= '0;
        end else begin
            mem_we <= '0;
            case (state)
                IDLE: if (start_s) begin
                    err_incomplete <= 1'b0;
                    err_bank       <= 1'b0;
                    wr_cnt         <= '0;
                    cnt            <= '0;
                end
                HDR: if (acc) begin
                    if (bank_bad)          err_bank       <= 1'b1;
                    else if (s_axis_tlast) err_incomplete <= 1'b1;
                    else begin
                        addr_q  <= s_axis_tdata[ADDR_LSB +: AW];
                        bank_q  <= hdr_bank;
                        burst_q <= s_axis_tdata[BURST_BIT];
                        cnt     <= '0;
                    end
                end
                DATA: if (acc) begin
                    for (int k = 0; k < NREG; k++)
                        if (cnt == CW'(k)) regs[k] <= s_axis_tdata;
                    cnt <= cnt + CW'(1);
                    if (s_axis_tlast && !entry_full) err_incomplete <= 1'b1;
                end
                WRITE, WRITE_LAST: begin
                    mem_addr <= addr_q;
                    mem_din  <= regs;
                    mem_we   <= NB'(1) << bank_q;
                    if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
                    // burst continues at the next address; wrap at 2^AW is intentional
                    if (state == WRITE && burst_q) begin
                        addr_q <= addr_q + AW'(1);
                        cnt    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_writer_burst.sv
// Scoreboard bench for mem_writer_burst (NREG=4, AW=8; NB=4 main instance, NB=3 for bank-range).
module tb_mem_writer_burst;

    logic         clk = 1'b0;
    logic         rst;
    logic         tvalid, tlast;
    logic [31:0]  tdata;
    logic         start4, start3, sel3;

    logic         tready4, busy4, done4, ei4, eb4;
    logic [7:0]   mem_addr4;
    logic [127:0] mem_din4;
    logic [3:0]   mem_we4;
    logic [15:0]  wr_cnt4;

    logic         tready3, busy3, done3, ei3, eb3;
    logic [7:0]   mem_addr3;
    logic [127:0] mem_din3;
    logic [2:0]   mem_we3;
    logic [15:0]  wr_cnt3;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0]   addr;
        logic [127:0] din;
        logic [3:0]   we;
        int           cyc;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_writer_burst #(.NREG(4), .NB(4), .AW(8)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready4), .s_axis_tdata(tdata), .s_axis_tlast(tlast),
        .mem_addr(mem_addr4), .mem_din(mem_din4), .mem_we(mem_we4),
        .START_REG(start4), .busy(busy4), .done(done4),
        .err_incomplete(ei4), .err_bank(eb4), .wr_cnt(wr_cnt4)
    );

    mem_writer_burst #(.NREG(4), .NB(3), .AW(8)) dut3 (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready3), .s_axis_tdata(tdata), .s_axis_tlast(tlast),
        .mem_addr(mem_addr3), .mem_din(mem_din3), .mem_we(mem_we3),
        .START_REG(start3), .busy(busy3), .done(done3),
        .err_incomplete(ei3), .err_bank(eb3), .wr_cnt(wr_cnt3)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [127:0] d, input logic [3:0] we, input int c);
        wr_t e;
        e.addr = a; e.din = d; e.we = we; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe must match the oldest expected write, 2 cycles after its last accept.
    always @(negedge clk) begin
        if (mem_we4 !== 4'b0) begin
            if (exp_q.size() == 0) chk("unexpected_write", 128'(mem_we4), 128'h0);
            else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 128'(mem_addr4), 128'(mon_e.addr));
                chk("wr_din", mem_din4, mon_e.din);
                chk("wr_we", 128'(mem_we4), 128'(mon_e.we));
                chk("wr_latency", 128'(cyc), 128'(mon_e.cyc));
            end
        end
        if (mem_we3 !== 3'b0) chk("nb3_unexpected_write", 128'(mem_we3), 128'h0);
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [31:0] d, input logic l, input bit gaps,
                        output int acc_cyc, output int waits);
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        tvalid = 1'b1; tdata = d; tlast = l; waits = 0;
        while (!(sel3 ? tready3 : tready4) && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 100) chk("accept_timeout", 128'h0, 128'h1);
        acc_cyc = cyc + 2;
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    function automatic bit cond(input int what);
        case (what)
            0:       return done4;
            1:       return !busy4;
            2:       return done3;
            3:       return !busy3;
            default: return busy4;
        endcase
    endfunction

    task automatic wait_for(input string nm, input int what);
        int n = 0;
        while (!cond(what) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 128'(cond(what)), 128'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a, w;
        logic [127:0] d;
        logic [7:0] ad;

        rst = 1'b1; tvalid = 1'b0; tdata = '0; tlast = 1'b0;
        start4 = 1'b0; start3 = 1'b0; sel3 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctl4", 128'({tready4, mem_we4, mem_addr4, busy4, done4, ei4, eb4, wr_cnt4}), 128'h0);
        chk("reset_din4", mem_din4, 128'h0);
        chk("reset_ctl3", 128'({tready3, mem_we3, mem_addr3, busy3, done3, ei3, eb3, wr_cnt3}), 128'h0);
        rst = 1'b0;

        // single entry, bank 2, addr 0x05
        start4 = 1'b1;
        send(32'h0000_0205, 1'b0, 1'b0, a, w);
        for (int i = 1; i <= 4; i++) send(32'(i), i == 4, 1'b0, a, w);
        push_exp(8'h05, {32'd4, 32'd3, 32'd2, 32'd1}, 4'b0100, a);
        wait_for("t1_done", 0);
        chk("t1_wr_cnt", 128'(wr_cnt4), 128'd1);
        chk("t1_errs", 128'({ei4, eb4}), 128'h0);
        start4 = 1'b0;
        wait_for("t1_idle", 1);

        // burst wrap: bank 1, FE -> FF -> 00, one bubble per entry
        start4 = 1'b1;
        send(32'h8000_01FE, 1'b0, 1'b0, a, w);
        ad = 8'hFE; d = '0;
        for (int i = 1; i <= 12; i++) begin
            send(32'(i), i == 12, 1'b0, a, w);
            if (i == 5 || i == 9) chk("burst_bubble", 128'(w), 128'd1);
            else                  chk("burst_nostall", 128'(w), 128'd0);
            d[32*((i-1)%4) +: 32] = 32'(i);
            if (i % 4 == 0) begin
                push_exp(ad, d, 4'b0010, a);
                ad = ad + 8'd1;
            end
        end
        wait_for("t2_done", 0);
        chk("t2_wr_cnt", 128'(wr_cnt4), 128'd3);
        chk("t2_errs", 128'({ei4, eb4}), 128'h0);
        start4 = 1'b0;
        wait_for("t2_idle", 1);

        // non-burst, two headers in one packet; second header has junk in ignored bits
        start4 = 1'b1;
        send(32'h0000_0310, 1'b0, 1'b0, a, w);
        for (int i = 1; i <= 4; i++) send(32'h10 + 32'(i), 1'b0, 1'b0, a, w);
        push_exp(8'h10, {32'h14, 32'h13, 32'h12, 32'h11}, 4'b1000, a);
        send(32'h7FF0_0022, 1'b0, 1'b0, a, w);
        for (int i = 1; i <= 4; i++) send(32'h20 + 32'(i), i == 4, 1'b0, a, w);
        push_exp(8'h22, {32'h24, 32'h23, 32'h22, 32'h21}, 4'b0001, a);
        wait_for("t3_done", 0);
        chk("t3_wr_cnt", 128'(wr_cnt4), 128'd2);
        start4 = 1'b0;
        wait_for("t3_idle", 1);

        // incomplete entry
        start4 = 1'b1;
        send(32'h0000_0101, 1'b0, 1'b0, a, w);
        send(32'd9, 1'b0, 1'b0, a, w);
        send(32'd10, 1'b1, 1'b0, a, w);
        wait_for("t4_done", 0);
        chk("t4_errs", 128'({ei4, eb4}), 128'b10);
        chk("t4_wr_cnt", 128'(wr_cnt4), 128'd0);
        start4 = 1'b0;
        wait_for("t4_idle", 1);
        chk("t4_sticky", 128'(ei4), 128'd1);
        start4 = 1'b1;
        wait_for("t4_restart", 4);
        chk("t4_cleared", 128'(ei4), 128'd0);

        // same single entry with random tvalid gaps
        send(32'h0000_0205, 1'b0, 1'b1, a, w);
        for (int i = 1; i <= 4; i++) send(32'(i), i == 4, 1'b1, a, w);
        push_exp(8'h05, {32'd4, 32'd3, 32'd2, 32'd1}, 4'b0100, a);
        wait_for("t5_done", 0);
        chk("t5_wr_cnt", 128'(wr_cnt4), 128'd1);
        chk("t5_errs", 128'({ei4, eb4}), 128'h0);
        start4 = 1'b0;
        wait_for("t5_idle", 1);

        // bad bank on NB=3 build: drained with tready held high
        sel3 = 1'b1; start3 = 1'b1;
        send(32'h0000_0300, 1'b0, 1'b0, a, w);
        for (int i = 0; i < 5; i++) begin
            send(32'hA0 + 32'(i), i == 4, 1'b0, a, w);
            chk("drain_tready", 128'(w), 128'd0);
        end
        wait_for("t6_done", 2);
        chk("t6_errs", 128'({ei3, eb3}), 128'b01);
        chk("t6_wr_cnt", 128'(wr_cnt3), 128'd0);
        start3 = 1'b0;
        wait_for("t6_idle", 3);
        sel3 = 1'b0;

        // reset mid-packet, then a clean packet
        start4 = 1'b1;
        send(32'h0000_0205, 1'b0, 1'b0, a, w);
        send(32'd1, 1'b0, 1'b0, a, w);
        send(32'd2, 1'b0, 1'b0, a, w);
        rst = 1'b1;
        @(negedge clk);
        chk("t7_reset_ctl", 128'({tready4, mem_we4, mem_addr4, busy4, done4, ei4, eb4, wr_cnt4}), 128'h0);
        chk("t7_reset_din", mem_din4, 128'h0);
        rst = 1'b0;
        send(32'h0000_0133, 1'b0, 1'b0, a, w);
        for (int i = 5; i <= 8; i++) send(32'(i), i == 8, 1'b0, a, w);
        push_exp(8'h33, {32'd8, 32'd7, 32'd6, 32'd5}, 4'b0010, a);
        wait_for("t7_done", 0);
        chk("t7_wr_cnt", 128'(wr_cnt4), 128'd1);
        start4 = 1'b0;
        wait_for("t7_idle", 1);

        repeat (5) @(negedge clk);
        chk("exp_q_empty", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
